// File: rtl/permutation_stream_if.sv
// Slice stream bus of the permutation unit: block control, input slice
// handshake and the registered output slice with its index.
interface permutation_stream_if #(
    parameter int N     = 5,
    parameter int CNT_W = 6
);
    logic             start;
    logic [1:0]       mode;
    logic [N*N-1:0]   matrixIn;
    logic             inValid;
    logic             putInput;
    logic [N*N-1:0]   matrixOut;
    logic             outValid;
    logic             outReady;
    logic [CNT_W-1:0] sliceIdx;
    logic             ready;
    logic             done;

    // Upstream/downstream environment driving the unit.
    modport master (
        output start, mode, matrixIn, inValid, outReady,
        input  putInput, matrixOut, outValid, sliceIdx, ready, done
    );

    // The permutation unit itself.
    modport slave (
        input  start, mode, matrixIn, inValid, outReady,
        output putInput, matrixOut, outValid, sliceIdx, ready, done
    );
endinterface

// File: rtl/permutation_stream.sv
// Streaming slice permutation: maps each N x N slice of a COUNT-slice block
// through identity, pi, inverse pi or transpose into a registered output
// stage with valid/ready backpressure and a done pulse at block end.
module permutation_stream #(
    parameter int N     = 5,
    parameter int COUNT = 64,
    parameter int INV3  = 2,
    parameter int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input logic                 clk,
    input logic                 rst,
    permutation_stream_if.slave bus
);
    localparam int                 W    = N * N;
    localparam logic [CNT_W-1:0]   LAST = CNT_W'(COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_FLUSH = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        MODE_ID  = 2'b00,
        MODE_PI  = 2'b01,
        MODE_IPI = 2'b10,
        MODE_TR  = 2'b11
    } mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     out_q, out_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;

    logic             put;
    logic             acc;
    logic             last;
    logic [W-1:0]     pi_map, ipi_map, tr_map, mapped;

    // Constant index wiring for each mapping; bit N*y+x holds A[x][y].
    for (genvar y = 0; y < N; y++) begin : g_y
        for (genvar x = 0; x < N; x++) begin : g_x
            localparam int PI_X  = (x + 3 * y) % N;
            localparam int PI_Y  = x;
            localparam int IPI_X = y;
            localparam int IPI_Y = (INV3 * ((x + N - y) % N)) % N;
            assign pi_map[N*y+x]  = bus.matrixIn[N*PI_Y+PI_X];
            assign ipi_map[N*y+x] = bus.matrixIn[N*IPI_Y+IPI_X];
            assign tr_map[N*y+x]  = bus.matrixIn[N*x+y];
        end
    end

    // Select the mapping chosen by the mode latched at block start.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        mapped = bus.matrixIn;
        case (mode_q)
            MODE_ID:  mapped = bus.matrixIn;
            MODE_PI:  mapped = pi_map;
            MODE_IPI: mapped = ipi_map;
            MODE_TR:  mapped = tr_map;
            default:  mapped = bus.matrixIn;
        endcase
    end

    assign put  = (state_q == S_RUN) && (!vld_q || bus.outReady);
    assign acc  = bus.inValid && put;
    assign last = (cnt_q == LAST);

    // Next-state logic for the block FSM, slice counter and output stage.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        idx_d   = idx_q;
        vld_d   = vld_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = mode_e'(bus.mode);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (acc && last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!vld_q || bus.outReady) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accepted slice overwrites the output stage even while the old
        // one is being consumed, so full-rate streaming has no bubble.
        if (acc) begin
            out_d = mapped;
            idx_d = cnt_q;
            vld_d = 1'b1;
            // Hold at the last index instead of wrapping; the counter is
            // not consulted again until the next start clears it.
            if (!last) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (vld_q && bus.outReady) begin
            vld_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_ID;
            cnt_q   <= '0;
            out_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.putInput  = put;
    assign bus.matrixOut = out_q;
    assign bus.outValid  = vld_q;
    assign bus.sliceIdx  = idx_q;
    assign bus.ready     = (state_q == S_IDLE);
    assign bus.done      = (state_q == S_DONE);
endmodule
